// File: rtl/fwd_pkg.sv
// Shared definitions for the operand-forwarding / interlock controller.
// Holds the forward-select constants, stage indices, the tracking-table
// entry type and the select-width helper.
package fwd_pkg;

  localparam int unsigned FWD_RF  = 0;  // select value: operand from register file
  localparam int unsigned STG_EX  = 0;
  localparam int unsigned STG_MEM = 1;
  localparam int unsigned STG_WB  = 2;

  // Widest register address the table can hold; narrower addresses are
  // zero-extended on entry, so comparisons stay exact.
  localparam int unsigned FWD_AW_MAX = 8;

  typedef struct packed {
    logic                  v;   // entry writes a nonzero register
    logic [FWD_AW_MAX-1:0] rd;  // destination register
    logic                  ld;  // result comes from memory
  } pipe_entry_t;

  function automatic int unsigned f_selw(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-operand priority comparator.
//   i_use   : operand is read in EX
//   i_reg   : source register address
//   i_pipe  : forwardable tracking entries, [0] = instruction now in EX
//   o_hit   : an in-flight producer was found
//   o_sel   : forward select (stage index of the producer next cycle)
//   o_is_ld : the winning producer is a load
module fwd_match
  import fwd_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned SELW   = 2
) (
  input  logic                    i_use,
  input  logic [REG_AW-1:0]       i_reg,
  input  pipe_entry_t [DEPTH-2:0] i_pipe,
  output logic                    o_hit,
  output logic [SELW-1:0]         o_sel,
  output logic                    o_is_ld
);

  always_comb begin
    o_hit   = 1'b0;
    o_sel   = SELW'(FWD_RF);
    o_is_ld = 1'b0;
    if (i_use && (i_reg != '0)) begin
      // Ascending scan with first-hit latch: the youngest producer wins.
      for (int unsigned j = STG_EX; j < DEPTH - 1; j++) begin
        if (!o_hit && i_pipe[j].v && (i_pipe[j].rd == FWD_AW_MAX'(i_reg))) begin
          o_hit   = 1'b1;
          o_sel   = SELW'(j + 1);
          o_is_ld = i_pipe[j].ld;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding and interlock controller for the five-stage pipeline.
// Tracks in-flight register writes from decode onwards, registers the
// EX-stage forward selects and raises a decode stall on load-use and
// MDU-busy hazards.
//   i_clk, i_rst          : clock, async active-high reset
//   i_hold                : global freeze of all state
//   i_flush               : kill the ID instruction (bubble into EX)
//   i_id_*                : decoded ID-stage instruction fields
//   o_stall               : hold IF/ID, insert bubble (combinational)
//   o_fwd_a, o_fwd_b      : registered EX operand selects (0 = register file)
//   o_mdu_busy            : MDU countdown active
//   o_stall_cnt           : stalled-cycle counter, wraps
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter  int unsigned REG_AW   = 5,
  parameter  int unsigned DEPTH    = 3,
  parameter  int unsigned LD_STAGE = STG_WB,
  parameter  int unsigned MDU_LAT  = 4,
  localparam int unsigned SELW     = f_selw(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_hold,
  input  logic              i_flush,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs,
  input  logic [REG_AW-1:0] i_id_rt,
  input  logic              i_id_use_rs,
  input  logic              i_id_use_rt,
  input  logic              i_id_wr,
  input  logic [REG_AW-1:0] i_id_rd,
  input  logic              i_id_is_load,
  input  logic              i_id_is_mdu,
  input  logic              i_id_use_hilo,
  output logic              o_stall,
  output logic [SELW-1:0]   o_fwd_a,
  output logic [SELW-1:0]   o_fwd_b,
  output logic              o_mdu_busy,
  output logic [31:0]       o_stall_cnt
);

  localparam int unsigned CNTW = $clog2(MDU_LAT + 1);

  typedef enum logic {
    MDU_IDLE,
    MDU_BUSY
  } mdu_state_t;

  // The last stage (WB) is never forwarded because the register file is
  // write-through, so only entries 0..DEPTH-2 are stored.
  pipe_entry_t [DEPTH-2:0] r_pipe;
  mdu_state_t              r_mdu_state;
  logic [CNTW-1:0]         r_mdu_cnt;
  logic [SELW-1:0]         r_fwd_a;
  logic [SELW-1:0]         r_fwd_b;
  logic [31:0]             r_stall_cnt;

  logic            w_hit_a, w_hit_b, w_ld_a, w_ld_b;
  logic [SELW-1:0] w_sel_a, w_sel_b;
  logic            w_load_use, w_mdu_stall, w_stall, w_accept;
  pipe_entry_t     w_new;

  fwd_match #(.REG_AW(REG_AW), .DEPTH(DEPTH), .SELW(SELW)) u_match_rs (
    .i_use   (i_id_use_rs),
    .i_reg   (i_id_rs),
    .i_pipe  (r_pipe),
    .o_hit   (w_hit_a),
    .o_sel   (w_sel_a),
    .o_is_ld (w_ld_a)
  );

  fwd_match #(.REG_AW(REG_AW), .DEPTH(DEPTH), .SELW(SELW)) u_match_rt (
    .i_use   (i_id_use_rt),
    .i_reg   (i_id_rt),
    .i_pipe  (r_pipe),
    .o_hit   (w_hit_b),
    .o_sel   (w_sel_b),
    .o_is_ld (w_ld_b)
  );

  always_comb begin
    w_load_use  = (w_hit_a && w_ld_a && (32'(w_sel_a) < LD_STAGE)) ||
                  (w_hit_b && w_ld_b && (32'(w_sel_b) < LD_STAGE));
    w_mdu_stall = (r_mdu_state == MDU_BUSY) && (i_id_use_hilo || i_id_is_mdu);
    w_stall     = i_id_valid && !i_flush && !i_rst && (w_load_use || w_mdu_stall);
    w_accept    = i_id_valid && !w_stall && !i_flush;
    w_new       = '0;
    if (w_accept) begin
      w_new.v  = i_id_wr && (i_id_rd != '0);
      w_new.rd = FWD_AW_MAX'(i_id_rd);
      w_new.ld = i_id_is_load;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pipe      <= '0;
      r_fwd_a     <= '0;
      r_fwd_b     <= '0;
      r_stall_cnt <= '0;
    end else if (!i_hold) begin
      r_pipe[0] <= w_new;
      for (int unsigned k = 1; k < DEPTH - 1; k++) begin
        r_pipe[k] <= r_pipe[k-1];
      end
      r_fwd_a <= w_accept ? w_sel_a : '0;
      r_fwd_b <= w_accept ? w_sel_b : '0;
      if (w_stall) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  // MDU countdown; an MDU issue is only accepted in IDLE because any
  // is_mdu instruction stalls while BUSY.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mdu_state <= MDU_IDLE;
      r_mdu_cnt   <= '0;
    end else if (!i_hold) begin
      case (r_mdu_state)
        MDU_IDLE: begin
          if (w_accept && i_id_is_mdu) begin
            r_mdu_cnt   <= CNTW'(MDU_LAT);
            r_mdu_state <= MDU_BUSY;
          end
        end
        MDU_BUSY: begin
          if (r_mdu_cnt == CNTW'(1)) begin
            r_mdu_cnt   <= '0;
            r_mdu_state <= MDU_IDLE;
          end else begin
            r_mdu_cnt <= r_mdu_cnt - 1'b1;
          end
        end
        default: begin
          r_mdu_cnt   <= '0;
          r_mdu_state <= MDU_IDLE;
        end
      endcase
    end
  end

  assign o_stall     = w_stall;
  assign o_fwd_a     = r_fwd_a;
  assign o_fwd_b     = r_fwd_b;
  assign o_mdu_busy  = (r_mdu_state == MDU_BUSY);
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned DEPTH    = 3;
  localparam int unsigned LD_STAGE = 2;
  localparam int unsigned MDU_LAT  = 4;
  localparam int unsigned SELW     = 2;

  logic              clk = 1'b0;
  logic              rst, hold, flush, id_valid;
  logic [REG_AW-1:0] rs, rt, rd;
  logic              use_rs, use_rt, wr, is_load, is_mdu, use_hilo;
  logic              stall, mdu_busy;
  logic [SELW-1:0]   fwd_a, fwd_b;
  logic [31:0]       stall_cnt;

  int checks = 0;
  int errors = 0;

  fwd_hazard_unit #(
    .REG_AW   (REG_AW),
    .DEPTH    (DEPTH),
    .LD_STAGE (LD_STAGE),
    .MDU_LAT  (MDU_LAT)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_hold        (hold),
    .i_flush       (flush),
    .i_id_valid    (id_valid),
    .i_id_rs       (rs),
    .i_id_rt       (rt),
    .i_id_use_rs   (use_rs),
    .i_id_use_rt   (use_rt),
    .i_id_wr       (wr),
    .i_id_rd       (rd),
    .i_id_is_load  (is_load),
    .i_id_is_mdu   (is_mdu),
    .i_id_use_hilo (use_hilo),
    .o_stall       (stall),
    .o_fwd_a       (fwd_a),
    .o_fwd_b       (fwd_b),
    .o_mdu_busy    (mdu_busy),
    .o_stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a history of what entered EX (newest first), the cycle
  // an MDU op was issued, and the expected registered outputs.
  typedef struct {
    bit          w;
    int unsigned r;
    bit          ld;
  } ent_t;

  ent_t        hist[$];
  int          nc;
  int          issue_at;
  int unsigned m_fa, m_fb;
  int unsigned m_scnt;

  function automatic void model_reset();
    ent_t e;
    e.w = 0; e.r = 0; e.ld = 0;
    hist.delete();
    for (int i = 0; i < DEPTH; i++) hist.push_back(e);
    nc       = 0;
    issue_at = -1000;
    m_fa     = 0;
    m_fb     = 0;
    m_scnt   = 0;
  endfunction

  // MDU is busy for the MDU_LAT cycles that follow the issue cycle.
  function automatic bit m_busy();
    return (nc >= issue_at + 1) && (nc <= issue_at + int'(MDU_LAT));
  endfunction

  // A producer that entered EX 'age' cycles ago sits in stage age+1 next
  // cycle; the WB-resident one (age DEPTH-1) is served by the register file.
  function automatic void model_op(input bit u, input int unsigned r,
                                   output int unsigned sel, output bit lu);
    sel = 0;
    lu  = 0;
    if (u && r != 0) begin
      for (int age = 0; age < int'(DEPTH) - 1; age++) begin
        if (hist[age].w && hist[age].r == r) begin
          sel = age + 1;
          lu  = hist[age].ld && (age + 1 < int'(LD_STAGE));
          break;
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_i(input bit v, input int a, input bit ua, input int b, input bit ub,
                       input bit w, input int d, input bit ld, input bit mdu, input bit hilo);
    id_valid = v;  rs = 5'(a); use_rs = ua; rt = 5'(b); use_rt = ub;
    wr = w; rd = 5'(d); is_load = ld; is_mdu = mdu; use_hilo = hilo;
    flush = 0; hold = 0;
  endtask

  // One clock: check stall before the edge, advance the model, check the
  // registered outputs just after the edge, return at the next negedge.
  task automatic tick();
    int unsigned sa, sb;
    bit la, lb, es, acc;
    ent_t e;
    #1;
    model_op(use_rs, int'(rs), sa, la);
    model_op(use_rt, int'(rt), sb, lb);
    es = id_valid && !flush && !rst && (la || lb || (m_busy() && (use_hilo || is_mdu)));
    chk("stall", {31'd0, stall}, {31'd0, es});
    @(posedge clk);
    if (!hold) begin
      acc  = id_valid && !es && !flush;
      e.w  = acc && wr && (rd != 0);
      e.r  = int'(rd);
      e.ld = is_load;
      hist.push_front(e);
      void'(hist.pop_back());
      m_fa = acc ? sa : 0;
      m_fb = acc ? sb : 0;
      if (acc && is_mdu) issue_at = nc;
      if (es) m_scnt++;
      nc++;
    end
    #1;
    chk("fwd_a", 32'(fwd_a), m_fa);
    chk("fwd_b", 32'(fwd_b), m_fb);
    chk("mdu_busy", {31'd0, mdu_busy}, {31'd0, m_busy()});
    chk("stall_cnt", stall_cnt, m_scnt);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base;
    rst = 1'b1;
    set_i(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    chk("rst_stall", {31'd0, stall}, 0);
    chk("rst_fwd_a", 32'(fwd_a), 0);
    chk("rst_fwd_b", 32'(fwd_b), 0);
    chk("rst_busy", {31'd0, mdu_busy}, 0);
    chk("rst_scnt", stall_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    // add r2 ; add r4,r2,r1
    set_i(1, 0, 0, 0, 0, 1, 2, 0, 0, 0); tick();
    set_i(1, 2, 1, 1, 1, 1, 4, 0, 0, 0); tick();
    chk("tp1_fwd_a", 32'(fwd_a), 1);
    chk("tp1_fwd_b", 32'(fwd_b), 0);

    // lw r3 ; add r5,r3,r3 -> one stall, then WB forward on both operands
    set_i(1, 0, 0, 0, 0, 1, 3, 1, 0, 0); tick();
    set_i(1, 3, 1, 3, 1, 1, 5, 0, 0, 0); tick();
    chk("tp2_bubble_fa", 32'(fwd_a), 0);
    tick();
    chk("tp2_fwd_a", 32'(fwd_a), 2);
    chk("tp2_fwd_b", 32'(fwd_b), 2);
    chk("tp2_scnt", stall_cnt, 1);

    // or r6 ; sub r6 ; and r7,r6 -> youngest producer
    set_i(1, 0, 0, 0, 0, 1, 6, 0, 0, 0); tick();
    tick();
    set_i(1, 6, 1, 0, 0, 1, 7, 0, 0, 0); tick();
    chk("tp3_fwd_a", 32'(fwd_a), 1);

    // load to r0 ; reader of r0
    set_i(1, 0, 0, 0, 0, 1, 0, 1, 0, 0); tick();
    set_i(1, 0, 1, 0, 1, 1, 9, 0, 0, 0); tick();
    chk("tp4_fwd_a", 32'(fwd_a), 0);
    chk("tp4_scnt", stall_cnt, 1);

    // mult ; mfhi -> 4 stall cycles
    set_i(1, 1, 1, 2, 1, 0, 0, 0, 1, 0); tick();
    set_i(1, 0, 0, 0, 0, 1, 8, 0, 0, 1);
    for (int i = 0; i < 4; i++) tick();
    chk("tp5_scnt", stall_cnt, 5);
    chk("tp5_busy", {31'd0, mdu_busy}, 0);
    tick();
    chk("tp5_scnt_after", stall_cnt, 5);

    // load-use with flush in the same cycle
    set_i(1, 0, 0, 0, 0, 1, 3, 1, 0, 0); tick();
    set_i(1, 3, 1, 3, 1, 1, 5, 0, 0, 0);
    flush = 1; tick();
    chk("tp6_fwd_a", 32'(fwd_a), 0);
    chk("tp6_fwd_b", 32'(fwd_b), 0);
    chk("tp6_scnt", stall_cnt, 5);

    // hold freezes everything, including the MDU count
    set_i(1, 1, 1, 2, 1, 0, 0, 0, 1, 0); tick();
    set_i(1, 5, 1, 6, 1, 1, 10, 0, 1, 1);
    hold = 1; tick(); tick(); tick();
    chk("hold_busy", {31'd0, mdu_busy}, 1);

    // reset pulse while BUSY
    set_i(1, 0, 0, 0, 0, 1, 8, 0, 0, 1);
    #1;
    chk("pre_rst_stall", {31'd0, stall}, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_stall", {31'd0, stall}, 0);
    chk("rst_mid_busy", {31'd0, mdu_busy}, 0);
    chk("rst_mid_fwd_a", 32'(fwd_a), 0);
    chk("rst_mid_fwd_b", 32'(fwd_b), 0);
    chk("rst_mid_scnt", stall_cnt, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_rst_scnt", stall_cnt, 0);

    // randomized traffic
    base = 0;
    for (int i = 0; i < 400; i++) begin
      set_i($urandom_range(0, 99) < 85,
            int'($urandom_range(0, 7)), $urandom_range(0, 99) < 70,
            int'($urandom_range(0, 7)), $urandom_range(0, 99) < 60,
            $urandom_range(0, 99) < 75, int'($urandom_range(0, 7)),
            $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 8,
            $urandom_range(0, 99) < 12);
      flush = ($urandom_range(0, 99) < 10);
      hold  = ($urandom_range(0, 99) < 10);
      tick();
      base++;
    end
    chk("rand_cycles", base, 400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised operand-forwarding and interlock controller for the five-stage integer pipeline. It tracks in-flight register writes itself, from decode onwards, and produces registered EX-stage forward selects for both ALU operands. It also raises a decode-stage stall for load-use hazards and for multiply/divide-unit (MDU) busy hazards, and keeps a stall performance counter. It sits between the ID/EX pipeline register and the operand muxes, and its stall drives the PC/IF-ID hold logic.

## Interface
- REG_AW, 5, register address width
- DEPTH, 3, forwardable stages EX..WB; select width SELW = $clog2(DEPTH)
- LD_STAGE, 2, first stage index (EX=0) at which load data may be forwarded
- MDU_LAT, 4, MDU busy cycles after issue (>=1)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- hold  in  1  global freeze; all state and outputs keep their values
- flush  in  1  kill the ID instruction; a bubble enters EX
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  REG_AW  source registers
- id_use_rs, id_use_rt  in  1  operand read in EX
- id_wr, id_rd  in  1, REG_AW  instruction writes register id_rd
- id_is_load  in  1  result comes from memory
- id_is_mdu  in  1  instruction issues to the MDU
- id_use_hilo  in  1  instruction reads HI/LO
- stall  out  1  hold IF/ID and insert a bubble (combinational)
- fwd_a, fwd_b  out  SELW  EX operand source: 0 = register file, k = result of stage k (registered)
- mdu_busy  out  1  MDU counter nonzero
- stall_cnt  out  32  total stalled cycles, wraps

## Operation
- Tracking table pipe[0..DEPTH-1], one entry per stage: {v, rd, ld}. pipe[0] is the instruction now in EX.
- Each non-hold cycle the table shifts: pipe[k+1] <= pipe[k].
  - pipe[0] <= {id_wr && id_rd!=0, id_rd, id_is_load} when the instruction is accepted: id_valid && !stall && !flush.
  - Otherwise pipe[0] <= 0 (bubble).
- Operand match for r ∈ {rs, rt} with use=1:
  - Scan j = 0..DEPTH-2 for pipe[j].v && pipe[j].rd == r; the smallest j (youngest producer) wins.
  - The next select is j+1.
  - A match at j = DEPTH-1 is not forwarded; the register file is write-through.
  - Register 0 never matches.
- Load-use stall: the winning match has ld = 1 and j+1 < LD_STAGE.
- MDU FSM:
  - IDLE (cnt == 0) goes to BUSY when an accepted id_is_mdu loads cnt = MDU_LAT.
  - BUSY decrements cnt each non-hold cycle and returns to IDLE at 0.
- MDU stall: cnt != 0 && (id_use_hilo || id_is_mdu).
- stall = id_valid && !flush && !rst && (load-use || MDU stall).
- fwd_a/fwd_b register the computed selects when the instruction is accepted; otherwise they register 0.
- stall_cnt increments on each non-hold cycle with stall = 1.

## Timing
- Reset values: pipe all invalid, cnt = 0, fwd_a = fwd_b = 0, mdu_busy = 0, stall_cnt = 0. stall is forced to 0 while rst is asserted.
- Select latency: 1 cycle. Selects are computed in ID and valid for the whole EX cycle of the same instruction.
- Load-use (defaults): stall for exactly 1 cycle. The consumer then enters EX with select 2 (WB).
- MDU: a consumer decoded in cycle T+1 after issue in cycle T stalls for MDU_LAT cycles and is accepted at T+MDU_LAT+1.
- flush together with a stall condition: flush wins, stall = 0, bubble inserted.
- hold together with any input: nothing changes, including cnt and stall_cnt.
- Reset asserted mid-MDU: cnt is cleared immediately; no stall after release.
- Both operands matching different producers: each select is resolved independently.

## Structure
- Package fwd_pkg holds:
  - FWD_RF = 0 and the stage-index constants;
  - the pipe entry struct typedef {v, rd, ld};
  - the SELW helper function.
- Sub-module fwd_match: a per-operand priority comparator returning {hit, sel, is_ld}, instantiated once for rs and once for rt.
- The top level holds the table, the MDU counter, the output registers and stall_cnt.

## Test plan
- add r2 accepted; next cycle add r4,r2,r1 → stall = 0, fwd_a = 1 during its EX cycle, fwd_b = 0.
- lw r3 then add r5,r3,r3 → stall = 1 for one cycle, bubble enters EX, then fwd_a = fwd_b = 2; stall_cnt = 1.
- or r6, then sub r6, then and r7,r6 → youngest producer wins, fwd_a = 1, not 2.
- Writer with rd = 0 followed by a reader of r0 → fwd_a = 0, no stall.
- mult (MDU_LAT = 4) then mfhi → stall asserted for exactly 4 cycles, mdu_busy falls with the last stall cycle, mfhi accepted in the 5th cycle after issue.
- Load-use stall with flush in the same cycle → stall = 0, fwd_a = fwd_b = 0 next cycle. rst pulse during MDU BUSY → mdu_busy = 0 immediately and all outputs return to reset values.
